// File: rtl/foc_pkg.sv
// Shared FOC definitions: default operand width, fixed-point scale and the
// scheduler state encoding used by the inverse-Clarke front end.
package foc_pkg;

   localparam int FOC_D_WIDTH = 32;
   localparam int FOC_Q_BITS  = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-valid search: grants the first valid channel at or after
// ptr, wrapping past the top channel back to 0.
module rr_pick #(
   parameter int N_CH = 4,
   localparam int IW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic [N_CH-1:0] valid,
   input  logic [IW-1:0]   ptr,
   output logic [N_CH-1:0] grant,
   output logic [IW-1:0]   idx
);

   logic found;
   int   j;

   // Scan channels in rotated order; the first hit wins and masks the rest.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N_CH; k++) begin
         j = (int'(ptr) + k) % N_CH;
         if (!found && valid[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/inv_clarke_sched.sv
// Shares one external inverse-Clarke datapath between N_CH channels. One
// request is in flight at a time; completion is timed purely by DP_LAT.
module inv_clarke_sched
   import foc_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int D_WIDTH = FOC_D_WIDTH,
   parameter int DP_LAT  = 1,
   localparam int IW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                            clk,
   input  logic                            rstb,
   input  logic [N_CH-1:0]                 req_valid,
   input  logic [N_CH-1:0][D_WIDTH-1:0]    req_alpha,
   input  logic [N_CH-1:0][D_WIDTH-1:0]    req_beta,
   output logic [N_CH-1:0]                 req_ready,
   output logic                            dp_start,
   output logic signed [D_WIDTH-1:0]       dp_alpha,
   output logic signed [D_WIDTH-1:0]       dp_beta,
   input  logic signed [D_WIDTH-1:0]       dp_a,
   input  logic signed [D_WIDTH-1:0]       dp_b,
   input  logic signed [D_WIDTH-1:0]       dp_c,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [IW-1:0]                   out_ch,
   output logic signed [D_WIDTH-1:0]       out_a,
   output logic signed [D_WIDTH-1:0]       out_b,
   output logic signed [D_WIDTH-1:0]       out_c,
   output logic                            busy
);

   state_t                     state;
   logic [IW-1:0]              rr_ptr;
   logic [IW-1:0]              cap_ch;
   logic [3:0]                 lat_cnt;
   logic signed [D_WIDTH-1:0]  cap_alpha;
   logic signed [D_WIDTH-1:0]  cap_beta;
   logic [N_CH-1:0]            pick_grant;
   logic [IW-1:0]              pick_idx;
   logic                       xfer;

   rr_pick #(.N_CH(N_CH)) u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   // Grants only offered while idle; reset masks them immediately.
   assign req_ready = (state == ST_IDLE && !rstb) ? pick_grant : '0;
   assign xfer      = |(req_valid & req_ready);
   assign dp_start  = (state == ST_ISSUE) && !rstb;
   assign dp_alpha  = cap_alpha;
   assign dp_beta   = cap_beta;
   assign busy      = (state != ST_IDLE);

   // Scheduler FSM: accept, issue, count out the datapath latency, hold result.
   always_ff @(posedge clk) begin
      if (rstb) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         lat_cnt   <= '0;
         cap_alpha <= '0;
         cap_beta  <= '0;
         cap_ch    <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_a     <= '0;
         out_b     <= '0;
         out_c     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  cap_alpha <= req_alpha[pick_idx];
                  cap_beta  <= req_beta[pick_idx];
                  cap_ch    <= pick_idx;
                  if (pick_idx == IW'(N_CH - 1)) rr_ptr <= '0;
                  else                           rr_ptr <= pick_idx + 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               lat_cnt <= 4'(DP_LAT);
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               lat_cnt <= lat_cnt - 1'b1;
               // Last counted cycle: datapath outputs are valid now.
               if (lat_cnt == 4'd1) begin
                  out_a     <= dp_a;
                  out_b     <= dp_b;
                  out_c     <= dp_c;
                  out_ch    <= cap_ch;
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_clarke_sched.sv
// Bench for inv_clarke_sched: behavioural inverse-Clarke datapath (Q10),
// transaction-level reference model, directed cases then random traffic.
module tb_inv_clarke_sched;

   localparam int N = 4;
   localparam int L1 = 1;

   logic clk = 1'b0;
   logic rstb;
   always #5 clk = ~clk;

   // DUT with DP_LAT=1
   logic [N-1:0]         req_valid, req_ready;
   logic [N-1:0][31:0]   req_alpha, req_beta, nx_alpha, nx_beta;
   logic                 dp_start, out_valid, out_ready, busy;
   logic signed [31:0]   dp_alpha, dp_beta, dp_a, dp_b, dp_c;
   logic signed [31:0]   out_a, out_b, out_c;
   logic [1:0]           out_ch;
   logic [95:0]          dp1_res;

   // DUT with DP_LAT=4
   logic [N-1:0]         r4_valid, r4_ready;
   logic [N-1:0][31:0]   r4_alpha, r4_beta;
   logic                 r4_start, r4_ov, r4_ordy, r4_busy;
   logic signed [31:0]   r4_dpal, r4_dpbe, r4_a, r4_b, r4_c, r4_oa, r4_ob, r4_oc;
   logic [1:0]           r4_ch;
   logic [95:0]          p4 [4];

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic               m_busy = 1'b0;
   int                 m_age = 0;
   int                 m_ptr = 0;
   int                 m_ch = 0;
   logic signed [31:0] m_al = '0, m_be = '0;
   int                 gq[$];

   inv_clarke_sched #(.N_CH(N), .D_WIDTH(32), .DP_LAT(L1)) u_dut (
      .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_alpha(req_alpha),
      .req_beta(req_beta), .req_ready(req_ready), .dp_start(dp_start),
      .dp_alpha(dp_alpha), .dp_beta(dp_beta), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
      .out_a(out_a), .out_b(out_b), .out_c(out_c), .busy(busy)
   );

   inv_clarke_sched #(.N_CH(N), .D_WIDTH(32), .DP_LAT(4)) u_dut4 (
      .clk(clk), .rstb(rstb), .req_valid(r4_valid), .req_alpha(r4_alpha),
      .req_beta(r4_beta), .req_ready(r4_ready), .dp_start(r4_start),
      .dp_alpha(r4_dpal), .dp_beta(r4_dpbe), .dp_a(r4_a), .dp_b(r4_b), .dp_c(r4_c),
      .out_valid(r4_ov), .out_ready(r4_ordy), .out_ch(r4_ch),
      .out_a(r4_oa), .out_b(r4_ob), .out_c(r4_oc), .busy(r4_busy)
   );

   // Inverse Clarke in Q10: b = (-alpha + sqrt3*beta)/2, c = (-alpha - sqrt3*beta)/2
   function automatic logic [95:0] clarke(input logic signed [31:0] al, input logic signed [31:0] be);
      longint s, b, c;
      s = (longint'(be) * 1773) >>> 10;
      b = (-longint'(al) + s) >>> 1;
      c = (-longint'(al) - s) >>> 1;
      return {al, b[31:0], c[31:0]};
   endfunction

   // Datapath models: result valid DP_LAT cycles after start, junk otherwise.
   always @(posedge clk)
      dp1_res <= dp_start ? clarke(dp_alpha, dp_beta) : {$urandom, $urandom, $urandom};
   assign dp_a = dp1_res[95:64];
   assign dp_b = dp1_res[63:32];
   assign dp_c = dp1_res[31:0];

   always @(posedge clk) begin
      p4[0] <= r4_start ? clarke(r4_dpal, r4_dpbe) : {$urandom, $urandom, $urandom};
      for (int k = 1; k < 4; k++) p4[k] <= p4[k-1];
   end
   assign r4_a = p4[3][95:64];
   assign r4_b = p4[3][63:32];
   assign r4_c = p4[3][31:0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // One cycle: drive at negedge, check against model, advance model.
   task automatic step(input logic [N-1:0] v, input logic ordy, input logic rst);
      logic [N-1:0] e_rdy;
      int           e_idx;
      logic         e_start, e_ov;
      logic [95:0]  e_res;
      @(negedge clk);
      rstb = rst; req_valid = v; out_ready = ordy;
      req_alpha = nx_alpha; req_beta = nx_beta;
      #1;
      e_rdy = '0; e_idx = -1;
      if (!m_busy && !rst)
         for (int k = 0; k < N; k++)
            if (e_idx < 0 && v[(m_ptr + k) % N]) begin
               e_idx = (m_ptr + k) % N;
               e_rdy[e_idx] = 1'b1;
            end
      e_start = m_busy && (m_age == 1) && !rst;
      e_ov    = m_busy && (m_age >= L1 + 2);
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("dp_start", 32'(dp_start), 32'(e_start));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      if (m_busy && m_age <= L1 + 1) begin
         chk("dp_alpha", dp_alpha, m_al);
         chk("dp_beta", dp_beta, m_be);
      end
      if (e_ov) begin
         e_res = clarke(m_al, m_be);
         chk("out_ch", 32'(out_ch), 32'(m_ch));
         chk("out_a", out_a, e_res[95:64]);
         chk("out_b", out_b, e_res[63:32]);
         chk("out_c", out_c, e_res[31:0]);
      end
      for (int k = 0; k < N; k++)
         if (req_ready[k] && req_valid[k]) gq.push_back(k);
      if (rst) begin
         m_busy = 1'b0; m_age = 0; m_ptr = 0;
      end else if (m_busy) begin
         if (e_ov && ordy) m_busy = 1'b0;
         else m_age++;
      end else if (e_idx >= 0) begin
         m_busy = 1'b1; m_age = 1; m_ch = e_idx;
         m_al = req_alpha[e_idx]; m_be = req_beta[e_idx];
         m_ptr = (e_idx + 1) % N;
      end
   endtask

   initial begin
      logic [95:0]  e4;
      logic [N-1:0] vv;
      int           exp_order [5];
      rstb = 1'b1; req_valid = '0; out_ready = 1'b0;
      req_alpha = '0; req_beta = '0; nx_alpha = '0; nx_beta = '0;
      r4_valid = '0; r4_alpha = '0; r4_beta = '0; r4_ordy = 1'b0;
      exp_order = '{0, 1, 2, 3, 0};

      // reset: ready masked even with every channel valid, outputs cleared
      step('1, 1'b1, 1'b1);
      step('1, 1'b1, 1'b1);
      chk("rst_out_ch", 32'(out_ch), 0);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_b", out_b, 0);
      chk("rst_out_c", out_c, 0);
      chk("rst_dp_alpha", dp_alpha, 0);
      chk("rst_dp_beta", dp_beta, 0);
      chk("rst4_ov", 32'(r4_ov), 0);

      // channel 0: alpha=1000 beta=0
      nx_alpha[0] = 32'd1000; nx_beta[0] = 32'd0;
      step(4'b0001, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      chk("d0_start", 32'(dp_start), 1);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      chk("d0_ov", 32'(out_valid), 1);
      chk("d0_ch", 32'(out_ch), 0);
      chk("d0_a", out_a, 32'd1000);
      chk("d0_b", out_b, -32'sd500);
      chk("d0_c", out_c, -32'sd500);

      // channel 2: alpha=0 beta=1024
      nx_alpha[2] = 32'd0; nx_beta[2] = 32'd1024;
      step(4'b0100, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      chk("d2_ch", 32'(out_ch), 2);
      chk("d2_a", out_a, 32'd0);
      chk("d2_b", out_b, 32'd886);
      chk("d2_c", out_c, -32'sd887);

      // backpressure: held 5 cycles in HOLD with everyone requesting
      nx_alpha[1] = 32'd12345; nx_beta[1] = -32'sd777;
      step(4'b0010, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step('1, 1'b0, 1'b0);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);

      // reset during WAIT: transaction dropped, next grant from channel 0
      nx_alpha[0] = 32'd4000; nx_beta[0] = 32'd99;
      step(4'b0001, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b1);
      step('0, 1'b1, 1'b0);
      chk("rw_ov", 32'(out_valid), 0);
      chk("rw_ch", 32'(out_ch), 0);
      chk("rw_a", out_a, 0);
      chk("rw_dp_alpha", dp_alpha, 0);
      step('0, 1'b1, 1'b0);
      chk("rw_ov2", 32'(out_valid), 0);

      // all channels valid: grant order 0,1,2,3,0
      gq.delete();
      for (int i = 0; i < 20; i++) step('1, 1'b1, 1'b0);
      chk("rr_count", 32'(gq.size()), 5);
      for (int i = 0; i < 5; i++)
         if (i < gq.size()) chk("rr_order", 32'(gq[i]), 32'(exp_order[i]));

      // randomized traffic with occasional reset
      vv = '0;
      for (int n = 0; n < 600; n++) begin
         for (int c = 0; c < N; c++) begin
            nx_alpha[c] = $urandom;
            nx_beta[c]  = $urandom;
            if ($urandom_range(3) == 0) vv[c] = ~vv[c];
         end
         step(vv, ($urandom_range(3) != 0), ($urandom_range(199) == 0));
      end
      step('0, 1'b1, 1'b0);

      // DP_LAT=4 instance: out_valid 6 cycles after accept
      @(negedge clk);
      r4_valid = 4'b1000; r4_alpha[3] = 32'd300; r4_beta[3] = -32'sd200; r4_ordy = 1'b0;
      #1;
      chk("l4_ready", 32'(r4_ready), 32'(4'b1000));
      e4 = clarke(32'sd300, -32'sd200);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         r4_valid = '0; r4_ordy = (k >= 8);
         #1;
         chk("l4_start", 32'(r4_start), 32'(k == 1));
         chk("l4_ov", 32'(r4_ov), 32'(k >= 6 && k <= 8));
         if (k == 6) begin
            chk("l4_ch", 32'(r4_ch), 3);
            chk("l4_a", r4_oa, e4[95:64]);
            chk("l4_b", r4_ob, e4[63:32]);
            chk("l4_c", r4_oc, e4[31:0]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
